// File: rtl/serial_word_framer.sv
// serial_word_framer
//
// Purpose:
//   Takes the registered single-bit stream from the upstream flop stage. It
//   hunts for the SYNC pattern and then deserialises the bits that follow
//   into WIDTH-bit words, MSB first. Each finished word goes downstream
//   through a one-entry valid/ready holding register. The block also reports
//   lock status and flags words lost to a full holding register.
//
// Parameters:
//   WIDTH  word width in bits (>= 2); also the width of the sync pattern
//   SYNC   pattern searched for while hunting
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   din         serial data bit
//   din_valid   din is sampled only when this is 1
//   resync      synchronous request to drop lock and return to hunting
//   dout        assembled word, stable while dout_valid is 1
//   dout_valid  holding register is full
//   dout_ready  downstream accepts when dout_valid & dout_ready
//   locked      1 while in the LOCKED state
//   overrun     one-cycle pulse: a completed word was dropped
module serial_word_framer #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SYNC  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             resync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             locked,
  output logic             overrun
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] window_q, window_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] window_shift;
  logic [WIDTH-1:0] word_shift;
  logic             word_done;

  assign window_shift = {window_q[WIDTH-2:0], din};
  assign word_shift   = {word_q[WIDTH-2:0], din};

  // Framing FSM.
  // resync overrides everything, so a word that would complete on the same
  // cycle is dropped silently rather than counted as an overrun.
  always_comb begin
    state_d   = state_q;
    window_d  = window_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;

    if (resync) begin
      state_d  = HUNT;
      window_d = '0;
      cnt_d    = '0;
    end else if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          window_d = window_shift;
          if (window_shift == SYNC) begin
            state_d = LOCKED;
            cnt_d   = '0;
          end
        end
        LOCKED: begin
          word_d = word_shift;
          if (cnt_q == LAST_BIT) begin
            cnt_d     = '0;
            word_done = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  // Holding register handshake.
  // A completed word is taken if the register is empty or is being drained
  // on this same cycle; otherwise the new word is lost and overrun pulses.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = 1'b0;

    if (word_done) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = word_shift;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= HUNT;
      window_q     <= '0;
      word_q       <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      window_q     <= window_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign locked     = (state_q == LOCKED);
  assign overrun    = overrun_q;

endmodule
